uart_cmd_tx: RTL and testbench

//  Transmit side of the host config link. Takes one (command, 32-bit value) request and sends it as an
//  8N1 UART frame: 1 command byte, then 4 value bytes, most significant first. This matches the frame
//  the config receiver decodes. Used for readback/echo of MAWG settings and for board-to-board config.

---
 rtl/uart_cmd_pkg.sv | 28 ++
 rtl/uart_cmd_tx_byte.sv | 73 +++++++
 rtl/uart_cmd_tx.sv | 82 ++++++++
 tb/tb_uart_cmd_tx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: command codes, frame sizing and state encodings shared by both ends of the config UART link.
// Frame size (and the checksum helper) depend on UART_CMD_TX_CHECKSUM_EN.
package uart_cmd_pkg;
    localparam logic [7:0] CMD_OUT_SEL       = 8'd0;
    localparam logic [7:0] CMD_WAVE_SEL      = 8'd1;
    localparam logic [7:0] CMD_FREQ_CTRL     = 8'd2;
    localparam logic [7:0] CMD_CHIRP_REVERSE = 8'd3;
    localparam logic [7:0] CMD_CHIRP_DELAY   = 8'd4;
    localparam logic [7:0] CMD_CHIRP_MIN     = 8'd5;
    localparam logic [7:0] CMD_CHIRP_MAX     = 8'd6;
    localparam logic [7:0] CMD_CHIRP_DIV     = 8'd7;
    localparam logic [7:0] CMD_CHIRP_INC     = 8'd8;
    localparam logic [7:0] CMD_PULSE_DUTY    = 8'd9;
    localparam logic [7:0] CMD_FM_CTR        = 8'd10;
    localparam logic [7:0] CMD_FM_DEV        = 8'd11;
    localparam logic [7:0] CMD_FM_DEMOD      = 8'd12;
    localparam logic [7:0] CMD_RESET_ALL     = 8'd15;
`ifdef UART_CMD_TX_CHECKSUM_EN
    localparam int FRAME_BYTES = 6;
    function automatic logic [7:0] frame_xor(input logic [7:0] cmd, input logic [31:0] value);
        return cmd ^ value[31:24] ^ value[23:16] ^ value[15:8] ^ value[7:0];
    endfunction
`else
    localparam int FRAME_BYTES = 5;
`endif
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} uart_state_t;
    typedef enum logic [1:0] {FR_IDLE, FR_BYTE, FR_GAP} frame_state_t;
endpackage

// File: rtl/uart_cmd_tx_byte.sv
// uart_tx_byte: single-byte 8N1 serializer. A start strobe loads a byte (also accepted on the done cycle,
// so bytes can follow each other with no idle time); done marks the last clk of the stop bit.
module uart_tx_byte
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    uart_state_t state, state_n;
    logic [15:0] tmr, tmr_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  sh, sh_n;
    logic        tx_n, tick, load;

    assign tick = tmr == 16'(CLKS_PER_BIT - 1);
    assign done = state == STOP && tick;
    assign load = start && (state == IDLE || done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
            idx   <= '0;
            sh    <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            tmr   <= tmr_n;
            idx   <= idx_n;
            sh    <= sh_n;
            tx    <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        tmr_n   = (state == IDLE || tick) ? '0 : tmr + 16'd1;
        idx_n   = idx;
        sh_n    = sh;
        tx_n    = tx;
        if (load) begin
            state_n = START;
            tmr_n   = '0;
            idx_n   = '0;
            sh_n    = data;
            tx_n    = 1'b0;
        end else if (tick) begin
            case (state)
                START: begin
                    state_n = DATA;
                    tx_n    = sh[0];
                end
                DATA: begin
                    state_n = idx == 3'd7 ? STOP : DATA;
                    idx_n   = idx + 3'd1;
                    sh_n    = sh >> 1;
                    tx_n    = idx == 3'd7 ? 1'b1 : sh[1];
                end
                STOP: begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: sends one (command, 32-bit value) request as a multi-byte 8N1 frame, value MSB byte first.
// Define UART_CMD_TX_CHECKSUM_EN to append an XOR checksum byte.
module uart_cmd_tx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int GAP_BITS     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [31:0] req_value,
    output logic        TX,
    output logic        busy
);
    localparam int FW       = FRAME_BYTES * 8;
    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;

    frame_state_t  fstate, fstate_n;
    logic [FW-1:0] frame, frame_n;
    logic [2:0]    byte_idx, byte_idx_n;
    logic [31:0]   gap_tmr, gap_tmr_n;
    logic          accept, byte_start, byte_done, last, gap_done;
    logic [7:0]    byte_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate   <= FR_IDLE;
            frame    <= '0;
            byte_idx <= '0;
            gap_tmr  <= '0;
        end else begin
            fstate   <= fstate_n;
            frame    <= frame_n;
            byte_idx <= byte_idx_n;
            gap_tmr  <= gap_tmr_n;
        end
    end

    // The frame register rotates so its top byte is always the byte being launched.
    always_comb begin
        req_ready  = fstate == FR_IDLE;
        busy       = !req_ready;
        accept     = req_valid && req_ready;
        last       = byte_idx == 3'(FRAME_BYTES - 1);
        gap_done   = fstate == FR_GAP && gap_tmr == 32'(GAP_CLKS - 1);
        byte_start = accept || gap_done || (byte_done && !last && GAP_BITS == 0);
        fstate_n   = fstate;
        frame_n    = frame;
        byte_idx_n = byte_idx;
        gap_tmr_n  = fstate == FR_GAP ? gap_tmr + 32'd1 : '0;
        if (accept) begin
            fstate_n = FR_BYTE;
`ifdef UART_CMD_TX_CHECKSUM_EN
            frame_n  = {req_cmd, req_value, frame_xor(req_cmd, req_value)};
`else
            frame_n  = {req_cmd, req_value};
`endif
        end else if (byte_start) begin
            fstate_n   = FR_BYTE;
            frame_n    = {frame[FW-9:0], frame[FW-1 -: 8]};
            byte_idx_n = byte_idx + 3'd1;
        end else if (byte_done) begin
            fstate_n   = last ? FR_IDLE : FR_GAP;
            byte_idx_n = last ? '0 : byte_idx;
        end
        byte_data = frame_n[FW-1 -: 8];
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (clk),
        .rst  (rst),
        .start(byte_start),
        .data (byte_data),
        .tx   (TX),
        .done (byte_done)
    );
endmodule

// File: tb/tb_uart_cmd_tx.sv
// tb_uart_cmd_tx: directed and random frames on two instances (GAP_BITS=1 and 0), decoded at bit centres
// and compared with a byte-list model of the frame built from the request.
module tb_uart_cmd_tx;
    import uart_cmd_pkg::*;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  valid = 2'b00;
    logic [1:0]  ready, tx, busy;
    logic [7:0]  cmd [2];
    logic [31:0] value [2];
    int          checks = 0, failures = 0, bad = 0, viol_tx = 0, viol_rdy = 0;
    logic        wav [$];
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(1)) dut (
        .clk(clk), .rst(rst), .req_valid(valid[0]), .req_ready(ready[0]),
        .req_cmd(cmd[0]), .req_value(value[0]), .TX(tx[0]), .busy(busy[0])
    );

    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(valid[1]), .req_ready(ready[1]),
        .req_cmd(cmd[1]), .req_value(value[1]), .TX(tx[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void build(input logic [7:0] c, input logic [31:0] v);
        exp_q = {c, v[31:24], v[23:16], v[15:8], v[7:0]};
`ifdef UART_CMD_TX_CHECKSUM_EN
        exp_q.push_back(c ^ v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0]);
`endif
    endfunction

    function automatic logic wav_at(input int i);
        return i < wav.size() ? wav[i] : 1'b1;
    endfunction

    task automatic request(input int k, input logic [7:0] c, input logic [31:0] v);
        cmd[k]   = c;
        value[k] = v;
        valid[k] = 1'b1;
        @(negedge clk);
        valid[k] = 1'b0;
    endtask

    // Records TX once per cycle while busy, then decodes each byte at its bit centres.
    task automatic capture_check(input int k, input logic [7:0] c, input logic [31:0] v, input int gap,
                                 input string tag);
        int n, per, base;
        logic [7:0] d;
        logic fr_ok;
        build(c, v);
        n   = exp_q.size();
        per = 10 * CPB + gap * CPB;
        wav = {};
        for (int t = 0; t < 2000 && busy[k]; t++) begin
            wav.push_back(tx[k]);
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 64'(wav.size()), 64'(n * 10 * CPB + (n - 1) * gap * CPB));
        for (int b = 0; b < n; b++) begin
            base  = b * per;
            fr_ok = wav_at(base + CPB / 2) == 1'b0 && wav_at(base + 9 * CPB + CPB / 2) == 1'b1;
            for (int i = 0; i < 8; i++) d[i] = wav_at(base + (i + 1) * CPB + CPB / 2);
            if (b < n - 1)
                for (int j = 0; j < gap * CPB; j++) fr_ok &= wav_at(base + 10 * CPB + j);
            check($sformatf("%s_byte%0d", tag, b), {fr_ok, d}, {1'b1, exp_q[b]});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if ((~tx & ~busy) != 2'b00) viol_tx++;
            if (ready[0] != (dut.fstate == FR_IDLE) || ready[1] != (dut0.fstate == FR_IDLE)) viol_rdy++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [7:0] c;
        logic [31:0] v;
        cmd[0] = '0; cmd[1] = '0; value[0] = '0; value[1] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 2'b11 || ready !== 2'b11 || busy !== 2'b00) bad++;
        end
        check("idle_after_reset", 64'(bad), 0);

        request(0, 8'h02, 32'h12345678);
        capture_check(0, 8'h02, 32'h12345678, 1, "single");

        @(negedge clk);
        cmd[0] = 8'h02; value[0] = 32'hCAFEF00D; valid[0] = 1'b1;
        @(negedge clk);
        cmd[0] = 8'h04; value[0] = 32'hDEADBEEF;
        capture_check(0, 8'h02, 32'hCAFEF00D, 1, "b2b_first");
        check("b2b_ready_after_frame", 64'(ready[0]), 1);
        @(negedge clk);
        check("b2b_restart_busy", 64'(busy[0]), 1);
        valid[0] = 1'b0;
        capture_check(0, 8'h04, 32'hDEADBEEF, 1, "b2b_second");

        @(negedge clk);
        request(0, 8'h55, 32'h5A0F3C96);
        repeat (50) @(negedge clk);
        check("rst_pre_busy", 64'(busy[0]), 1);
        check("rst_pre_tx", 64'(tx[0]), 0);
        #1 rst = 1'b1;
        #1;
        check("rst_tx", 64'(tx[0]), 1);
        check("rst_busy", 64'(busy[0]), 0);
        check("rst_ready", 64'(ready[0]), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        request(0, 8'h0F, 32'h00000000);
        capture_check(0, 8'h0F, 32'h00000000, 1, "post_rst");

        @(negedge clk);
        request(1, 8'h00, 32'h00000003);
        capture_check(1, 8'h00, 32'h00000003, 0, "gap0");

        for (int r = 0; r < 8; r++) begin
            k = int'($urandom_range(0, 1));
            c = 8'($urandom);
            v = $urandom;
            @(negedge clk);
            request(k, c, v);
            capture_check(k, c, v, k == 0 ? 1 : 0, $sformatf("rnd%0d", r));
        end

        check("tx_low_while_idle", 64'(viol_tx), 0);
        check("ready_vs_state", 64'(viol_rdy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
